spi_cmd_arbiter: RTL and testbench

SPI_CMD_ARBITER -- requirements
Module: spi_cmd_arbiter

---
 rtl/spi_cmd_arbiter.sv | 127 ++++++++++++
 tb/tb_spi_cmd_arbiter.sv | 299 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_cmd_arbiter.sv
// Purpose: round-robin arbiter sharing one SPI master between 4 register-write requesters.
// Latency: grant -> m_start in 1 cycle; done 1 cycle after master busy falls (or after timeout).
// Backpressure: requesters hold req_valid until a req_ready pulse; one transaction in flight at a time.
module spi_cmd_arbiter #(
  parameter int TIMEOUT_CYC = 1023
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  req_valid,
  input  logic [15:0] req_addr,
  input  logic [31:0] req_data,
  output logic [3:0]  req_ready,
  output logic [3:0]  done,
  output logic        m_start,
  output logic [15:0] m_data_in,
  input  logic        m_busy,
  output logic        arb_busy,
  output logic        err_flag,
  input  logic        err_clr
);

  localparam int CW = (TIMEOUT_CYC < 1) ? 1 : $clog2(TIMEOUT_CYC + 1);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    START   = 3'd1,
    WAIT_HI = 3'd2,
    WAIT_LO = 3'd3,
    DONE    = 3'd4
  } state_t;

  state_t        state;
  logic [1:0]    rr_ptr;
  logic [1:0]    gnt;
  logic [CW-1:0] wait_cnt;

  logic          gnt_found;
  logic [1:0]    gnt_idx;
  logic [1:0]    gnt_cand;
  logic          timeout;

  assign timeout = (wait_cnt == CW'(TIMEOUT_CYC));

  // Pick the first valid requester at or after rr_ptr, wrapping modulo 4.
  always_comb begin
    gnt_found = 1'b0;
    gnt_idx   = rr_ptr;
    gnt_cand  = rr_ptr;
    for (int i = 0; i < 4; i++) begin
      gnt_cand = rr_ptr + 2'(i);
      if (!gnt_found && req_valid[gnt_cand]) begin
        gnt_found = 1'b1;
        gnt_idx   = gnt_cand;
      end
    end
  end

  // Transaction FSM with registered pulses, frame capture, timeout and sticky error.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      rr_ptr    <= 2'd0;
      gnt       <= 2'd0;
      wait_cnt  <= '0;
      m_start   <= 1'b0;
      m_data_in <= 16'h0000;
      req_ready <= 4'b0000;
      done      <= 4'b0000;
      arb_busy  <= 1'b0;
      err_flag  <= 1'b0;
    end else begin
      m_start   <= 1'b0;
      req_ready <= 4'b0000;
      done      <= 4'b0000;
      // Clear first so a timeout later in this block overrides it (set wins).
      if (err_clr) err_flag <= 1'b0;
      case (state)
        IDLE: begin
          if (gnt_found) begin
            gnt       <= gnt_idx;
            m_data_in <= {req_addr[gnt_idx*4 +: 4], 4'b0000, req_data[gnt_idx*8 +: 8]};
            m_start   <= 1'b1;
            req_ready <= 4'b0001 << gnt_idx;
            arb_busy  <= 1'b1;
            state     <= START;
          end
        end
        START: begin
          wait_cnt <= '0;
          state    <= WAIT_HI;
        end
        WAIT_HI: begin
          if (timeout) begin
            err_flag <= 1'b1;
            done     <= 4'b0001 << gnt;
            state    <= DONE;
          end else begin
            wait_cnt <= wait_cnt + CW'(1);
            if (m_busy) state <= WAIT_LO;
          end
        end
        WAIT_LO: begin
          if (timeout) begin
            err_flag <= 1'b1;
            done     <= 4'b0001 << gnt;
            state    <= DONE;
          end else if (!m_busy) begin
            done  <= 4'b0001 << gnt;
            state <= DONE;
          end else begin
            wait_cnt <= wait_cnt + CW'(1);
          end
        end
        DONE: begin
          rr_ptr   <= gnt + 2'd1;
          arb_busy <= 1'b0;
          state    <= IDLE;
        end
        default: begin
          arb_busy <= 1'b0;
          state    <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_spi_cmd_arbiter.sv
// Bench for spi_cmd_arbiter: expected transactions are queued at issue time and
// checked by an independent monitor on each done pulse, plus directed checks.
module tb_spi_cmd_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  req_valid;
  logic [15:0] req_addr;
  logic [31:0] req_data;
  logic [3:0]  req_ready;
  logic [3:0]  done;
  logic        m_start;
  logic [15:0] m_data_in;
  logic        m_busy;
  logic        arb_busy;
  logic        err_flag;
  logic        err_clr;

  always #5 clk = ~clk;

  spi_cmd_arbiter #(.TIMEOUT_CYC(15)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_addr  (req_addr),
    .req_data  (req_data),
    .req_ready (req_ready),
    .done      (done),
    .m_start   (m_start),
    .m_data_in (m_data_in),
    .m_busy    (m_busy),
    .arb_busy  (arb_busy),
    .err_flag  (err_flag),
    .err_clr   (err_clr)
  );

  // Simple SPI master + slave register file: busy for 4 cycles after a start.
  logic       master_en;
  logic       mbusy_r;
  logic [2:0] mcnt;
  logic [7:0] regfile [16];
  assign m_busy = mbusy_r;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      mbusy_r <= 1'b0;
      mcnt    <= 3'd0;
    end else if (m_start && master_en) begin
      mbusy_r <= 1'b1;
      mcnt    <= 3'd3;
      regfile[m_data_in[15:12]] <= m_data_in[7:0];
    end else if (mbusy_r) begin
      if (mcnt == 3'd0) mbusy_r <= 1'b0;
      else mcnt <= mcnt - 3'd1;
    end
  end

  int compared   = 0;
  int mismatched = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    compared++;
    if (act !== expv) begin
      mismatched++;
      $display("FAIL %s: got %0h, expected %0h", name, act, expv);
    end
  endtask

  typedef struct {
    logic [1:0]  idx;
    logic [15:0] frame;
    logic        err;
  } exp_t;

  exp_t exp_q[$];

  task automatic push_exp(input logic [1:0] idx, input logic [15:0] frame, input logic err);
    exp_t e;
    e.idx   = idx;
    e.frame = frame;
    e.err   = err;
    exp_q.push_back(e);
  endtask

  // Monitor: tracks each transaction from m_start and scores it on done.
  int          cyc_no = 0;
  int          last_start = 0;
  bit          have_start = 0;
  logic [15:0] cur_frame = 16'h0;
  logic [3:0]  cur_rdy = 4'h0;
  bit          stable_bad = 0;

  always @(negedge clk) begin
    exp_t e;
    cyc_no++;
    if (rst) begin
      have_start = 0;
    end else begin
      if (m_start) begin
        if (have_start) check("start_gap_ge5", 32'(cyc_no - last_start >= 5), 32'd1);
        have_start = 1;
        last_start = cyc_no;
        cur_frame  = m_data_in;
        cur_rdy    = req_ready;
        stable_bad = 0;
      end else if (arb_busy && done == 4'h0 && m_data_in !== cur_frame) begin
        stable_bad = 1;
      end
      if (done != 4'h0) begin
        if (exp_q.size() == 0) begin
          check("unexpected_done", 32'(done), 32'd0);
        end else begin
          e = exp_q.pop_front();
          check("done_onehot", 32'(done), 32'(4'b0001 << e.idx));
          check("frame", 32'(cur_frame), 32'(e.frame));
          check("ready_onehot", 32'(cur_rdy), 32'(4'b0001 << e.idx));
          check("err_at_done", 32'(err_flag), 32'(e.err));
          check("frame_stable", 32'(stable_bad), 32'd0);
        end
      end
    end
  end

  // Raise the masked requests; each drops (and scrambles its fields) on its ready.
  task automatic issue(input logic [3:0] mask);
    logic [3:0] pend;
    int n;
    pend = mask;
    n = 0;
    req_valid = mask;
    while (pend != 4'h0 && n < 200) begin
      @(negedge clk);
      n++;
      for (int i = 0; i < 4; i++) begin
        if (pend[i] && req_ready[i]) begin
          pend[i] = 1'b0;
          req_valid[i] = 1'b0;
          req_addr[4*i +: 4] = 4'hF;
          req_data[8*i +: 8] = 8'hEE;
        end
      end
    end
    check("ready_wait", 32'(pend), 32'd0);
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (arb_busy && n < 100);
    check("idle_wait", 32'(arb_busy), 32'd0);
  endtask

  task automatic set_req(input int i, input logic [3:0] a, input logic [7:0] d);
    req_addr[4*i +: 4] = a;
    req_data[8*i +: 8] = d;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int n;
    int nd;
    bit saw_done;

    // Reset values, with requester 0 already pending to test first-cycle grant.
    rst = 1'b1;
    err_clr = 1'b0;
    master_en = 1'b1;
    req_addr = 16'h0;
    req_data = 32'h0;
    req_valid = 4'b0001;
    set_req(0, 4'd3, 8'hAB);
    push_exp(2'd0, 16'h30AB, 1'b0);
    repeat (3) @(negedge clk);
    check("rst_m_start", 32'(m_start), 32'd0);
    check("rst_m_data_in", 32'(m_data_in), 32'h0);
    check("rst_req_ready", 32'(req_ready), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_arb_busy", 32'(arb_busy), 32'd0);
    check("rst_err_flag", 32'(err_flag), 32'd0);

    // Single write, granted in the first cycle after release.
    rst = 1'b0;
    @(negedge clk);
    check("first_cycle_start", 32'(m_start), 32'd1);
    check("first_cycle_ready", 32'(req_ready), 32'h1);
    check("first_cycle_frame", 32'(m_data_in), 32'h30AB);
    req_valid = 4'b0000;
    set_req(0, 4'hF, 8'hEE);
    wait_idle();
    check("regfile3", 32'(regfile[3]), 32'hAB);

    // Round robin from a fresh pointer with all four held continuously.
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    set_req(0, 4'h8, 8'h50);
    set_req(1, 4'h9, 8'h51);
    set_req(2, 4'hA, 8'h52);
    set_req(3, 4'hB, 8'h53);
    push_exp(2'd0, 16'h8050, 1'b0);
    push_exp(2'd1, 16'h9051, 1'b0);
    push_exp(2'd2, 16'hA052, 1'b0);
    push_exp(2'd3, 16'hB053, 1'b0);
    push_exp(2'd0, 16'h8050, 1'b0);
    req_valid = 4'b1111;
    nd = 0;
    n = 0;
    while (nd < 5 && n < 300) begin
      @(negedge clk);
      n++;
      if (done != 4'h0) nd++;
    end
    req_valid = 4'b0000;
    check("rr_done_count", 32'(nd), 32'd5);
    wait_idle();

    // Pointer: requester 2 completes, then 0 and 2 both ask -> 0 first, then 2.
    set_req(2, 4'h5, 8'hC2);
    push_exp(2'd2, 16'h50C2, 1'b0);
    issue(4'b0100);
    wait_idle();
    set_req(0, 4'h1, 8'h11);
    set_req(2, 4'h2, 8'h22);
    push_exp(2'd0, 16'h1011, 1'b0);
    push_exp(2'd2, 16'h2022, 1'b0);
    issue(4'b0101);
    wait_idle();

    // Timeout with the master silent.
    master_en = 1'b0;
    set_req(1, 4'h7, 8'h77);
    push_exp(2'd1, 16'h7077, 1'b1);
    issue(4'b0010);
    n = 0;
    while (done == 4'h0 && n < 60) begin
      @(negedge clk);
      n++;
    end
    check("timeout_latency", 32'(n), 32'd17);
    wait_idle();
    repeat (3) @(negedge clk);
    check("err_sticky", 32'(err_flag), 32'd1);
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    check("err_cleared", 32'(err_flag), 32'd0);

    // err_clr held across a timeout: set wins.
    set_req(3, 4'hC, 8'h3C);
    push_exp(2'd3, 16'hC03C, 1'b1);
    err_clr = 1'b1;
    issue(4'b1000);
    wait_idle();
    err_clr = 1'b0;
    @(negedge clk);
    check("err_after_clr_hold", 32'(err_flag), 32'd0);

    // Reset asserted while in WAIT_LO aborts with no done.
    master_en = 1'b1;
    set_req(0, 4'h2, 8'h99);
    issue(4'b0001);
    repeat (2) @(negedge clk);
    check("in_wait_lo_busy", 32'(arb_busy), 32'd1);
    check("in_wait_lo_mbusy", 32'(m_busy), 32'd1);
    rst = 1'b1;
    #1;
    check("abort_m_start", 32'(m_start), 32'd0);
    check("abort_m_data_in", 32'(m_data_in), 32'h0);
    check("abort_req_ready", 32'(req_ready), 32'd0);
    check("abort_done", 32'(done), 32'd0);
    check("abort_arb_busy", 32'(arb_busy), 32'd0);
    check("abort_err_flag", 32'(err_flag), 32'd0);
    saw_done = 0;
    repeat (5) begin
      @(negedge clk);
      if (done != 4'h0) saw_done = 1;
    end
    rst = 1'b0;
    repeat (10) begin
      @(negedge clk);
      if (done != 4'h0) saw_done = 1;
    end
    check("abort_no_done", 32'(saw_done), 32'd0);
    check("resume_idle", 32'(arb_busy), 32'd0);
    check("scoreboard_empty", 32'(exp_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
